exe_pipe_slice: RTL and testbench

- Scalar 5-stage pipeline slice holding three pieces of the core.
  - IF/ID pipeline latch (pc, instruction).
  - ID/EXE pipeline latch.
  - EXE stage: 12-op ALU, MEM/WB operand forwarding, valid/allow-in handshake, store-signal generation toward EXE/MEM.
- Sits between the decode logic (ID) and the EXE/MEM register.

---
 rtl/exe_pipe_slice_if.sv | 74 +++++++
 rtl/exe_pipe_slice.sv | 136 +++++++++++++
 tb/tb_exe_pipe_slice.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_pipe_slice_if.sv
// exe_pipe_slice_if
//   Bundles every non-clock/reset signal of the EXE pipeline slice.
//   The slice itself connects through the slave modport.
//   Its surroundings (IF, ID, MEM, WB, or a testbench) use the master modport.
//   Signal groups:
//     fs_* / ds_allow_in / ds_pc / ds_inst  : IF/ID latch
//     ds_to_es_valid / stall / id_*         : decoded op from ID
//     ms_rf_* / wb_rf_*                     : forwarding sources
//     ms_allow_in / es_*                    : EXE handshake and EXE/MEM bus
interface exe_pipe_slice_if;
  logic        fs_to_ds_valid;
  logic        ds_allow_in;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic [31:0] ds_pc;
  logic [31:0] ds_inst;

  logic        ds_to_es_valid;
  logic        stall;
  logic [31:0] id_pc;
  logic [11:0] id_alu_op;
  logic [31:0] id_alu_src1;
  logic [31:0] id_alu_src2;
  logic [4:0]  id_rf_raddr1;
  logic [4:0]  id_rf_raddr2;
  logic        id_sram_en;
  logic [3:0]  id_sram_we;
  logic [31:0] id_sram_addr;
  logic [3:0]  id_rf_we;
  logic [4:0]  id_rf_waddr;

  logic        ms_allow_in;
  logic [3:0]  ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_rf_wdata;
  logic [3:0]  wb_rf_we;
  logic [4:0]  wb_rf_waddr;
  logic [31:0] wb_rf_wdata;

  logic        es_allow_in;
  logic        es_to_ms_valid;
  logic [31:0] es_pc;
  logic        es_sram_en;
  logic [3:0]  es_sram_we;
  logic [31:0] es_sram_addr;
  logic [31:0] es_sram_wdata;
  logic [3:0]  es_rf_we;
  logic [4:0]  es_rf_waddr;
  logic [31:0] es_rf_wdata;

  modport slave (
    input  fs_to_ds_valid, ds_allow_in, fs_pc, fs_inst,
    output ds_pc, ds_inst,
    input  ds_to_es_valid, stall, id_pc, id_alu_op, id_alu_src1, id_alu_src2,
           id_rf_raddr1, id_rf_raddr2, id_sram_en, id_sram_we, id_sram_addr,
           id_rf_we, id_rf_waddr,
    input  ms_allow_in, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
           wb_rf_we, wb_rf_waddr, wb_rf_wdata,
    output es_allow_in, es_to_ms_valid, es_pc, es_sram_en, es_sram_we,
           es_sram_addr, es_sram_wdata, es_rf_we, es_rf_waddr, es_rf_wdata
  );

  modport master (
    output fs_to_ds_valid, ds_allow_in, fs_pc, fs_inst,
    input  ds_pc, ds_inst,
    output ds_to_es_valid, stall, id_pc, id_alu_op, id_alu_src1, id_alu_src2,
           id_rf_raddr1, id_rf_raddr2, id_sram_en, id_sram_we, id_sram_addr,
           id_rf_we, id_rf_waddr,
    output ms_allow_in, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
           wb_rf_we, wb_rf_waddr, wb_rf_wdata,
    input  es_allow_in, es_to_ms_valid, es_pc, es_sram_en, es_sram_we,
           es_sram_addr, es_sram_wdata, es_rf_we, es_rf_waddr, es_rf_wdata
  );
endinterface

// File: rtl/exe_pipe_slice.sv
// exe_pipe_slice
//   Scalar pipeline slice containing the IF/ID latch, the ID/EXE latch and
//   the EXE stage (12-op one-hot ALU, MEM/WB operand forwarding,
//   valid/allow-in handshake and store signals toward EXE/MEM).
//   Ports:
//     clk   : pipeline clock, all state updates on the rising edge
//     reset : asynchronous, active-high; clears every latch and es_valid
//     bus   : exe_pipe_slice_if.slave carrying all datapath/handshake signals
module exe_pipe_slice (
  input  logic              clk,
  input  logic              reset,
  exe_pipe_slice_if.slave   bus
);

  logic [31:0] ds_pc_r;
  logic [31:0] ds_inst_r;

  logic        es_valid;
  logic [31:0] es_pc_r;
  logic [11:0] es_alu_op;
  logic [31:0] es_src1;
  logic [31:0] es_src2;
  logic [4:0]  es_raddr1;
  logic [4:0]  es_raddr2;
  logic        es_sram_en_r;
  logic [3:0]  es_sram_we_r;
  logic [31:0] es_sram_addr_r;
  logic [3:0]  es_rf_we_r;
  logic [4:0]  es_rf_waddr_r;

  logic        es_allow_in;
  logic        es_load;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] alu_result;

  // EXE always finishes in one cycle, so it only blocks when MEM refuses
  // the instruction currently held.
  assign es_allow_in = !es_valid || bus.ms_allow_in;
  assign es_load     = bus.ds_to_es_valid && !bus.stall;

  // IF/ID latch: captures the fetched pc/instruction when ID accepts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ds_pc_r   <= '0;
      ds_inst_r <= '0;
    end else if (bus.fs_to_ds_valid && bus.ds_allow_in) begin
      ds_pc_r   <= bus.fs_pc;
      ds_inst_r <= bus.fs_inst;
    end
  end

  // ID/EXE latch: a stall turns the incoming slot into a bubble, but the
  // payload is left untouched so a held instruction is never overwritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_valid       <= 1'b0;
      es_pc_r        <= '0;
      es_alu_op      <= '0;
      es_src1        <= '0;
      es_src2        <= '0;
      es_raddr1      <= '0;
      es_raddr2      <= '0;
      es_sram_en_r   <= 1'b0;
      es_sram_we_r   <= '0;
      es_sram_addr_r <= '0;
      es_rf_we_r     <= '0;
      es_rf_waddr_r  <= '0;
    end else if (es_allow_in) begin
      es_valid <= es_load;
      if (es_load) begin
        es_pc_r        <= bus.id_pc;
        es_alu_op      <= bus.id_alu_op;
        es_src1        <= bus.id_alu_src1;
        es_src2        <= bus.id_alu_src2;
        es_raddr1      <= bus.id_rf_raddr1;
        es_raddr2      <= bus.id_rf_raddr2;
        es_sram_en_r   <= bus.id_sram_en;
        es_sram_we_r   <= bus.id_sram_we;
        es_sram_addr_r <= bus.id_sram_addr;
        es_rf_we_r     <= bus.id_rf_we;
        es_rf_waddr_r  <= bus.id_rf_waddr;
      end
    end
  end

  // Operand forwarding: MEM holds the younger result so it wins over WB.
  // Register 0 is never forwarded because address 0 means "not a register".
  always_comb begin
    opa = es_src1;
    if (es_raddr1 != 5'd0 && bus.ms_rf_we != 4'd0 && bus.ms_rf_waddr == es_raddr1)
      opa = bus.ms_rf_wdata;
    else if (es_raddr1 != 5'd0 && bus.wb_rf_we != 4'd0 && bus.wb_rf_waddr == es_raddr1)
      opa = bus.wb_rf_wdata;

    opb = es_src2;
    if (es_raddr2 != 5'd0 && bus.ms_rf_we != 4'd0 && bus.ms_rf_waddr == es_raddr2)
      opb = bus.ms_rf_wdata;
    else if (es_raddr2 != 5'd0 && bus.wb_rf_we != 4'd0 && bus.wb_rf_waddr == es_raddr2)
      opb = bus.wb_rf_wdata;
  end

  // One-hot ALU as an AND-OR mux; an all-zero op yields zero.
  always_comb begin
    alu_result = '0;
    alu_result = alu_result | ({32{es_alu_op[0]}}  & (opa + opb));
    alu_result = alu_result | ({32{es_alu_op[1]}}  & (opa - opb));
    alu_result = alu_result | ({32{es_alu_op[2]}}  & {31'd0, ($signed(opa) < $signed(opb))});
    alu_result = alu_result | ({32{es_alu_op[3]}}  & {31'd0, (opa < opb)});
    alu_result = alu_result | ({32{es_alu_op[4]}}  & (opa & opb));
    alu_result = alu_result | ({32{es_alu_op[5]}}  & ~(opa | opb));
    alu_result = alu_result | ({32{es_alu_op[6]}}  & (opa | opb));
    alu_result = alu_result | ({32{es_alu_op[7]}}  & (opa ^ opb));
    alu_result = alu_result | ({32{es_alu_op[8]}}  & (opa << opb[4:0]));
    alu_result = alu_result | ({32{es_alu_op[9]}}  & (opa >> opb[4:0]));
    alu_result = alu_result | ({32{es_alu_op[10]}} & 32'($signed(opa) >>> opb[4:0]));
    alu_result = alu_result | ({32{es_alu_op[11]}} & opb);
  end

  assign bus.ds_pc   = ds_pc_r;
  assign bus.ds_inst = ds_inst_r;

  // Side-effecting enables are suppressed for bubbles; the rest of the
  // bus simply shows whatever the latch holds.
  assign bus.es_allow_in    = es_allow_in;
  assign bus.es_to_ms_valid = es_valid;
  assign bus.es_pc          = es_pc_r;
  assign bus.es_sram_en     = es_valid & es_sram_en_r;
  assign bus.es_sram_we     = es_valid ? es_sram_we_r : 4'd0;
  assign bus.es_sram_addr   = es_sram_addr_r;
  assign bus.es_sram_wdata  = opb;
  assign bus.es_rf_we       = es_valid ? es_rf_we_r : 4'd0;
  assign bus.es_rf_waddr    = es_rf_waddr_r;
  assign bus.es_rf_wdata    = alu_result;

endmodule

// File: tb/tb_exe_pipe_slice.sv
// tb_exe_pipe_slice
//   Self-checking bench for exe_pipe_slice: directed cases with fixed
//   expected constants, then randomized traffic compared against a
//   transaction-level reference model (one held op plus a valid flag).
module tb_exe_pipe_slice;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  exe_pipe_slice_if bus ();

  exe_pipe_slice dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] pc;
    logic [11:0] op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [3:0]  rf_we;
    logic [4:0]  rf_waddr;
  } op_t;

  // Reference model state: the op sitting in EXE, whether it is real,
  // and the IF/ID contents.
  logic        m_valid;
  op_t         m_op;
  logic [31:0] m_ds_pc;
  logic [31:0] m_ds_inst;

  // Compares one observed value with the expected one and counts it.
  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic op_t capture_id();
    op_t o;
    o.pc        = bus.id_pc;
    o.op        = bus.id_alu_op;
    o.s1        = bus.id_alu_src1;
    o.s2        = bus.id_alu_src2;
    o.r1        = bus.id_rf_raddr1;
    o.r2        = bus.id_rf_raddr2;
    o.sram_en   = bus.id_sram_en;
    o.sram_we   = bus.id_sram_we;
    o.sram_addr = bus.id_sram_addr;
    o.rf_we     = bus.id_rf_we;
    o.rf_waddr  = bus.id_rf_waddr;
    return o;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] src);
    if (r == 0) return src;
    if (bus.ms_rf_we != 0 && bus.ms_rf_waddr == r) return bus.ms_rf_wdata;
    if (bus.wb_rf_we != 0 && bus.wb_rf_waddr == r) return bus.wb_rf_wdata;
    return src;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
    int idx;
    int sh;
    longint sa;
    longint sb;
    idx = -1;
    for (int i = 0; i < 12; i++) if (op[i]) idx = i;
    sh = int'(b % 32);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (idx)
      0:  return 32'(longint'(a) + longint'(b));
      1:  return 32'(longint'(a) - longint'(b));
      2:  return (sa < sb) ? 32'd1 : 32'd0;
      3:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return 32'(longint'(a) * (longint'(1) << sh));
      9:  return 32'(longint'(a) / (longint'(1) << sh));
      10: return 32'(sa >>> sh);
      11: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_valid   = 1'b0;
    m_op      = '{default: '0};
    m_ds_pc   = '0;
    m_ds_inst = '0;
  endtask

  // Full comparison of every output against the reference model.
  task automatic check_all(input string tag);
    logic [31:0] a;
    logic [31:0] b;
    a = fwd(m_op.r1, m_op.s1);
    b = fwd(m_op.r2, m_op.s2);
    check_output({tag, ".ds_pc"},     bus.ds_pc,   m_ds_pc);
    check_output({tag, ".ds_inst"},   bus.ds_inst, m_ds_inst);
    check_output({tag, ".allow_in"},  32'(bus.es_allow_in),    32'(!m_valid || bus.ms_allow_in));
    check_output({tag, ".valid"},     32'(bus.es_to_ms_valid), 32'(m_valid));
    check_output({tag, ".es_pc"},     bus.es_pc, m_op.pc);
    check_output({tag, ".sram_en"},   32'(bus.es_sram_en), 32'(m_valid && m_op.sram_en));
    check_output({tag, ".sram_we"},   32'(bus.es_sram_we), m_valid ? 32'(m_op.sram_we) : 32'd0);
    check_output({tag, ".sram_addr"}, bus.es_sram_addr, m_op.sram_addr);
    check_output({tag, ".sram_wdata"}, bus.es_sram_wdata, b);
    check_output({tag, ".rf_we"},     32'(bus.es_rf_we), m_valid ? 32'(m_op.rf_we) : 32'd0);
    check_output({tag, ".rf_waddr"},  32'(bus.es_rf_waddr), 32'(m_op.rf_waddr));
    check_output({tag, ".rf_wdata"},  bus.es_rf_wdata, alu_ref(m_op.op, a, b));
  endtask

  // Advances one clock: model next state is taken from the inputs that
  // are stable across the edge, then time moves to the next falling edge.
  task automatic clock_cycle();
    logic        nv;
    op_t         nop;
    logic [31:0] npc;
    logic [31:0] ninst;
    nv    = m_valid;
    nop   = m_op;
    npc   = m_ds_pc;
    ninst = m_ds_inst;
    if (bus.fs_to_ds_valid && bus.ds_allow_in) begin
      npc   = bus.fs_pc;
      ninst = bus.fs_inst;
    end
    if (!m_valid || bus.ms_allow_in) begin
      nv = bus.ds_to_es_valid && !bus.stall;
      if (nv) nop = capture_id();
    end
    @(posedge clk);
    m_valid   = nv;
    m_op      = nop;
    m_ds_pc   = npc;
    m_ds_inst = ninst;
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.fs_to_ds_valid = 0; bus.ds_allow_in = 0; bus.fs_pc = 0; bus.fs_inst = 0;
    bus.ds_to_es_valid = 0; bus.stall = 0; bus.id_pc = 0; bus.id_alu_op = 0;
    bus.id_alu_src1 = 0; bus.id_alu_src2 = 0; bus.id_rf_raddr1 = 0; bus.id_rf_raddr2 = 0;
    bus.id_sram_en = 0; bus.id_sram_we = 0; bus.id_sram_addr = 0;
    bus.id_rf_we = 0; bus.id_rf_waddr = 0;
    bus.ms_allow_in = 1; bus.ms_rf_we = 0; bus.ms_rf_waddr = 0; bus.ms_rf_wdata = 0;
    bus.wb_rf_we = 0; bus.wb_rf_waddr = 0; bus.wb_rf_wdata = 0;
  endtask

  // Presents one op from ID and clocks it into EXE.
  task automatic apply_stimulus(input logic [31:0] pc, input logic [11:0] op,
                                input logic [31:0] s1, input logic [31:0] s2,
                                input logic [4:0] r1, input logic [4:0] r2);
    bus.ds_to_es_valid = 1; bus.stall = 0; bus.ms_allow_in = 1;
    bus.id_pc = pc; bus.id_alu_op = op; bus.id_alu_src1 = s1; bus.id_alu_src2 = s2;
    bus.id_rf_raddr1 = r1; bus.id_rf_raddr2 = r2;
    bus.id_sram_en = 1; bus.id_sram_we = 4'hf; bus.id_sram_addr = pc + 32'h100;
    bus.id_rf_we = 4'hf; bus.id_rf_waddr = 5'd9;
    clock_cycle();
    bus.ds_to_es_valid = 0;
  endtask

  task automatic randomize_inputs();
    int k;
    bus.fs_to_ds_valid = 1'($urandom);
    bus.ds_allow_in    = 1'($urandom);
    bus.fs_pc          = $urandom;
    bus.fs_inst        = $urandom;
    bus.ds_to_es_valid = ($urandom_range(0, 3) != 0);
    bus.stall          = ($urandom_range(0, 4) == 0);
    bus.id_pc          = $urandom;
    k                  = $urandom_range(0, 12);
    bus.id_alu_op      = (k == 12) ? 12'd0 : 12'(1 << k);
    bus.id_alu_src1    = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 | $urandom : $urandom;
    bus.id_alu_src2    = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 40) : $urandom;
    bus.id_rf_raddr1   = 5'($urandom_range(0, 3));
    bus.id_rf_raddr2   = 5'($urandom_range(0, 3));
    bus.id_sram_en     = 1'($urandom);
    bus.id_sram_we     = 4'($urandom);
    bus.id_sram_addr   = $urandom;
    bus.id_rf_we       = 4'($urandom);
    bus.id_rf_waddr    = 5'($urandom);
    bus.ms_allow_in    = ($urandom_range(0, 3) != 0);
    bus.ms_rf_we       = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
    bus.ms_rf_waddr    = 5'($urandom_range(0, 3));
    bus.ms_rf_wdata    = $urandom;
    bus.wb_rf_we       = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
    bus.wb_rf_waddr    = 5'($urandom_range(0, 3));
    bus.wb_rf_wdata    = $urandom;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive_idle();
    model_reset();

    // Reset state
    @(negedge clk);
    #1;
    check_output("rst.allow_in", 32'(bus.es_allow_in), 32'd1);
    check_output("rst.valid", 32'(bus.es_to_ms_valid), 32'd0);
    check_output("rst.rf_we", 32'(bus.es_rf_we), 32'd0);
    check_output("rst.ds_pc", bus.ds_pc, 32'd0);
    check_all("rst");
    reset = 1'b0;
    clock_cycle();
    #1;
    check_all("post_rst");

    // IF/ID load then hold
    bus.fs_to_ds_valid = 1; bus.ds_allow_in = 1;
    bus.fs_pc = 32'h1c00_0000; bus.fs_inst = 32'h0280_0404;
    clock_cycle();
    bus.ds_allow_in = 0; bus.fs_pc = 32'h1c00_0004; bus.fs_inst = 32'hdead_beef;
    #1;
    check_output("ifid.pc", bus.ds_pc, 32'h1c00_0000);
    check_output("ifid.inst", bus.ds_inst, 32'h0280_0404);
    clock_cycle();
    #1;
    check_output("ifid.hold_pc", bus.ds_pc, 32'h1c00_0000);
    check_output("ifid.hold_inst", bus.ds_inst, 32'h0280_0404);
    bus.fs_to_ds_valid = 0;

    // ALU sweep on fixed operands
    apply_stimulus(32'h100, 12'h001, 32'hFFFF_FFF0, 32'h4, 0, 0); #1;
    check_output("alu.add", bus.es_rf_wdata, 32'hFFFF_FFF4); check_all("alu_add");
    apply_stimulus(32'h104, 12'h004, 32'hFFFF_FFF0, 32'h4, 0, 0); #1;
    check_output("alu.slt", bus.es_rf_wdata, 32'h1);
    apply_stimulus(32'h108, 12'h008, 32'hFFFF_FFF0, 32'h4, 0, 0); #1;
    check_output("alu.sltu", bus.es_rf_wdata, 32'h0);
    apply_stimulus(32'h10c, 12'h400, 32'hFFFF_FFF0, 32'h4, 0, 0); #1;
    check_output("alu.sra", bus.es_rf_wdata, 32'hFFFF_FFFF);
    apply_stimulus(32'h110, 12'h200, 32'hFFFF_FFF0, 32'h4, 0, 0); #1;
    check_output("alu.srl", bus.es_rf_wdata, 32'h0FFF_FFFF);
    apply_stimulus(32'h114, 12'h800, 32'hFFFF_FFF0, 32'h4, 0, 0); #1;
    check_output("alu.lui", bus.es_rf_wdata, 32'h4);
    check_all("alu_lui");

    // Forwarding priority on operand 1 (add with src2 = 0 exposes operand 1)
    apply_stimulus(32'h200, 12'h001, 32'h0, 32'h0, 5'd5, 5'd0);
    bus.ms_rf_we = 4'hf; bus.ms_rf_waddr = 5'd5; bus.ms_rf_wdata = 32'h11;
    bus.wb_rf_we = 4'hf; bus.wb_rf_waddr = 5'd5; bus.wb_rf_wdata = 32'h22;
    #1;
    check_output("fwd.mem", bus.es_rf_wdata, 32'h11);
    check_all("fwd_mem");
    bus.ms_rf_we = 4'h0;
    #1;
    check_output("fwd.wb", bus.es_rf_wdata, 32'h22);
    bus.ms_rf_we = 4'hf;
    apply_stimulus(32'h204, 12'h001, 32'h0, 32'h0, 5'd0, 5'd0);
    bus.ms_rf_we = 4'hf; bus.ms_rf_waddr = 5'd0; bus.ms_rf_wdata = 32'h11;
    bus.wb_rf_we = 4'hf; bus.wb_rf_waddr = 5'd0; bus.wb_rf_wdata = 32'h22;
    #1;
    check_output("fwd.r0", bus.es_rf_wdata, 32'h0);
    bus.ms_rf_we = 0; bus.wb_rf_we = 0;

    // Backpressure, with a simultaneous stall that must not insert a bubble
    apply_stimulus(32'h300, 12'h040, 32'h5, 32'ha, 0, 0);
    bus.ms_allow_in = 0; bus.stall = 1;
    bus.ds_to_es_valid = 1; bus.id_pc = 32'h304; bus.id_alu_op = 12'h001;
    #1;
    check_output("bp.allow_in", 32'(bus.es_allow_in), 32'd0);
    clock_cycle();
    #1;
    check_output("bp.hold_pc", bus.es_pc, 32'h300);
    check_output("bp.hold_valid", 32'(bus.es_to_ms_valid), 32'd1);
    check_output("bp.hold_res", bus.es_rf_wdata, 32'hf);
    check_all("bp_hold");
    bus.stall = 0; bus.ms_allow_in = 1;
    #1;
    check_output("bp.release", 32'(bus.es_allow_in), 32'd1);
    clock_cycle();
    bus.ds_to_es_valid = 0;
    #1;
    check_output("bp.next_pc", bus.es_pc, 32'h304);
    check_all("bp_next");

    // Stall turns the slot into a bubble
    bus.ds_to_es_valid = 1; bus.stall = 1; bus.ms_allow_in = 1;
    bus.id_sram_we = 4'hf; bus.id_rf_we = 4'hf; bus.id_sram_en = 1;
    clock_cycle();
    bus.ds_to_es_valid = 0; bus.stall = 0;
    #1;
    check_output("stall.valid", 32'(bus.es_to_ms_valid), 32'd0);
    check_output("stall.sram_we", 32'(bus.es_sram_we), 32'd0);
    check_output("stall.rf_we", 32'(bus.es_rf_we), 32'd0);
    check_all("stall");

    // Randomized traffic with occasional asynchronous reset
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      #1;
      check_all("rand");
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        #1;
        model_reset();
        check_all("rand_rst");
        reset = 1'b0;
      end
      clock_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
